// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word fetches over a req/ack
// port and hands each word plus its PC to decode through a one-entry buffer.
// Redirects restart fetch; misaligned targets surface as a fault word.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        out_fault,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DRAIN, S_VALID, S_FAULT, S_HALT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_next_q, pc_next_d;
  logic [31:0] out_inst_q, out_inst_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic        out_fault_q, out_fault_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic        imem_req_q, imem_req_d;

  logic        take_redir;
  logic [31:0] redir_tgt;

  // Next-state and datapath: per-state handling, then a shared redirect rule.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pc_next_d   = pc_next_q;
    out_inst_d  = out_inst_q;
    out_pc_d    = out_pc_q;
    out_fault_d = out_fault_q;
    out_valid_d = out_valid_q;
    fetch_cnt_d = fetch_cnt_q;
    take_redir  = 1'b0;
    redir_tgt   = redirect_pc;

    case (state_q)
      S_IDLE: begin
        if (redirect_valid) take_redir = 1'b1;
        else                state_d    = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          // Data returned alongside a redirect is stale and is dropped.
          if (redirect_valid) begin
            take_redir = 1'b1;
          end else begin
            out_inst_d  = imem_rdata;
            out_pc_d    = pc_q;
            out_fault_d = 1'b0;
            out_valid_d = 1'b1;
            pc_d        = pc_q + 32'd4;
            state_d     = S_VALID;
          end
        end else if (redirect_valid) begin
          // Request already on the bus: keep the address until it is acked.
          pc_next_d = redirect_pc;
          state_d   = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Latest redirect wins, including one arriving with the ack.
        redir_tgt = redirect_valid ? redirect_pc : pc_next_q;
        pc_next_d = redir_tgt;
        if (imem_ack) take_redir = 1'b1;
      end
      S_VALID: begin
        if (redirect_valid) begin
          take_redir = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          fetch_cnt_d = fetch_cnt_q + 32'd1;
          state_d     = S_FETCH;
        end
      end
      S_FAULT: begin
        if (redirect_valid) begin
          take_redir = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_HALT;
        end
      end
      S_HALT: begin
        if (redirect_valid) take_redir = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (take_redir) begin
      pc_d        = redir_tgt;
      out_valid_d = 1'b0;
      out_fault_d = 1'b0;
      state_d     = S_FETCH;
      if (redir_tgt[1:0] != 2'b00) begin
        out_valid_d = 1'b1;
        out_fault_d = 1'b1;
        out_inst_d  = 32'h0;
        out_pc_d    = redir_tgt;
        state_d     = S_FAULT;
      end
    end

    imem_req_d = (state_d == S_FETCH) || (state_d == S_DRAIN);
  end

  // State registers, async active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      pc_next_q   <= RESET_PC;
      out_inst_q  <= 32'h0;
      out_pc_q    <= RESET_PC;
      out_fault_q <= 1'b0;
      out_valid_q <= 1'b0;
      fetch_cnt_q <= 32'h0;
      imem_req_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pc_next_q   <= pc_next_d;
      out_inst_q  <= out_inst_d;
      out_pc_q    <= out_pc_d;
      out_fault_q <= out_fault_d;
      out_valid_q <= out_valid_d;
      fetch_cnt_q <= fetch_cnt_d;
      imem_req_q  <= imem_req_d;
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = pc_q;
  assign out_valid = out_valid_q;
  assign out_inst  = out_inst_q;
  assign out_pc    = out_pc_q;
  assign out_fault = out_fault_q;
  assign fetch_cnt = fetch_cnt_q;

endmodule
